// File: rtl/ifid_hazard_ctrl_if.sv
// rtl/ifid_hazard_ctrl_if.sv - hazard inputs and pipeline-control outputs for the IF/ID hazard controller
interface ifid_hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             IDEX_MemRead;
    logic [REG_W-1:0] IDEX_Rt;
    logic [REG_W-1:0] IFID_Rs;
    logic [REG_W-1:0] IFID_Rt;
    logic             branch_taken;
    logic             imem_ready;
    logic             PC_write;
    logic             IFID_write;
    logic             IF_flush;
    logic             bubble;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Pipeline side: supplies hazard information, consumes the enables.
    modport master (
        output IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt, branch_taken, imem_ready,
        input  PC_write, IFID_write, IF_flush, bubble, stall_cnt, flush_cnt
    );

    // Controller side.
    modport slave (
        input  IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt, branch_taken, imem_ready,
        output PC_write, IFID_write, IF_flush, bubble, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/ifid_hazard_ctrl.sv
// rtl/ifid_hazard_ctrl.sv - IF/ID hazard and fetch-sequencing controller with stall/flush counters
module ifid_hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    ifid_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        INIT       = 2'd0,
        RUN        = 2'd1,
        FLUSH_PEND = 2'd2
    } state_t;

    state_t           state;
    state_t           nextState;
    logic             loadUse;
    logic             pcWrite;
    logic             ifidWrite;
    logic             ifFlush;
    logic             bubbleReq;
    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] flushCnt;

    // Load in EX writes a register the instruction in ID reads; r0 never hazards.
    assign loadUse = hz.IDEX_MemRead && (hz.IDEX_Rt != REG_W'(0)) &&
                     ((hz.IDEX_Rt == hz.IFID_Rs) || (hz.IDEX_Rt == hz.IFID_Rt));

    // State register; reset always re-enters INIT so IF/ID gets re-flushed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= INIT;
        end else begin
            state <= nextState;
        end
    end

    // Next state and zero-latency hazard outputs; reset forces a flush-and-bubble pattern.
    always_comb begin
        nextState = state;
        pcWrite   = 1'b0;
        ifidWrite = 1'b0;
        ifFlush   = 1'b0;
        bubbleReq = 1'b0;
        if (!reset) begin
            nextState = INIT;
            ifFlush   = 1'b1;
            bubbleReq = 1'b1;
        end else begin
            case (state)
                INIT: begin
                    ifidWrite = 1'b1;
                    ifFlush   = 1'b1;
                    bubbleReq = 1'b1;
                    nextState = RUN;
                end
                RUN: begin
                    if (loadUse) begin
                        // Branch in the same cycle depends on the stalled instruction.
                        bubbleReq = 1'b1;
                    end else if (hz.branch_taken) begin
                        pcWrite   = 1'b1;
                        ifidWrite = 1'b1;
                        ifFlush   = 1'b1;
                        if (!hz.imem_ready) begin
                            nextState = FLUSH_PEND;
                        end
                    end else if (!hz.imem_ready) begin
                        bubbleReq = 1'b1;
                    end else begin
                        pcWrite   = 1'b1;
                        ifidWrite = 1'b1;
                    end
                end
                FLUSH_PEND: begin
                    // The outstanding word is wrong-path; PC already holds the target.
                    if (hz.imem_ready) begin
                        ifidWrite = 1'b1;
                        ifFlush   = 1'b1;
                        nextState = RUN;
                    end
                end
                default: begin
                    nextState = INIT;
                end
            endcase
        end
    end

    // Saturating performance counters, qualified by the cycle's own outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (!pcWrite && (state == RUN || state == FLUSH_PEND) && stallCnt != '1) begin
                stallCnt <= stallCnt + 1'b1;
            end
            if (ifFlush && state != INIT && flushCnt != '1) begin
                flushCnt <= flushCnt + 1'b1;
            end
        end
    end

    assign hz.PC_write   = pcWrite;
    assign hz.IFID_write = ifidWrite;
    assign hz.IF_flush   = ifFlush;
    assign hz.bubble     = bubbleReq;
    assign hz.stall_cnt  = stallCnt;
    assign hz.flush_cnt  = flushCnt;
endmodule

// File: tb/tb_ifid_hazard_ctrl.sv
// tb/tb_ifid_hazard_ctrl.sv - scoreboard bench for ifid_hazard_ctrl against a rule-level model
module tb_ifid_hazard_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ifid_hazard_ctrl_if #(.REG_W(5), .CNT_W(16)) hz16 ();
    ifid_hazard_ctrl_if #(.REG_W(5), .CNT_W(4))  hz4 ();

    ifid_hazard_ctrl #(.REG_W(5), .CNT_W(16)) dut16 (.clk(clk), .reset(reset), .hz(hz16.slave));
    ifid_hazard_ctrl #(.REG_W(5), .CNT_W(4))  dut4  (.clk(clk), .reset(reset), .hz(hz4.slave));

    typedef struct {
        int   step;
        logic pcw;
        logic ifw;
        logic fl;
        logic bub;
        int   st16;
        int   fc16;
        int   st4;
        int   fc4;
    } exp_t;

    exp_t sb[$];
    int   tests  = 0;
    int   errors = 0;
    int   stepNo = 0;

    // Reference model state: in the one cycle after reset, or waiting to discard a stale fetch.
    bit mInit = 1'b1;
    bit mPend = 1'b0;
    int mStall = 0;
    int mFlush = 0;

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string name, input int stp, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, stp, got, exp);
        end
    endtask

    task automatic apply(input bit rst, input bit mr, input int rtE, input int rs, input int rt,
                         input bit br, input bit rdy);
        exp_t e;
        bit   lu;
        @(posedge clk);
        #1;
        reset = rst;
        hz16.IDEX_MemRead = mr;  hz4.IDEX_MemRead = mr;
        hz16.IDEX_Rt = 5'(rtE);  hz4.IDEX_Rt = 5'(rtE);
        hz16.IFID_Rs = 5'(rs);   hz4.IFID_Rs = 5'(rs);
        hz16.IFID_Rt = 5'(rt);   hz4.IFID_Rt = 5'(rt);
        hz16.branch_taken = br;  hz4.branch_taken = br;
        hz16.imem_ready = rdy;   hz4.imem_ready = rdy;

        lu = mr && (rtE != 0) && ((rtE == rs) || (rtE == rt));
        e.step = stepNo;
        if (!rst)          {e.pcw, e.ifw, e.fl, e.bub} = 4'b0011;
        else if (mInit)    {e.pcw, e.ifw, e.fl, e.bub} = 4'b0111;
        else if (mPend)    {e.pcw, e.ifw, e.fl, e.bub} = rdy ? 4'b0110 : 4'b0000;
        else if (lu)       {e.pcw, e.ifw, e.fl, e.bub} = 4'b0001;
        else if (br)       {e.pcw, e.ifw, e.fl, e.bub} = 4'b1110;
        else if (!rdy)     {e.pcw, e.ifw, e.fl, e.bub} = 4'b0001;
        else               {e.pcw, e.ifw, e.fl, e.bub} = 4'b1100;
        e.st16 = sat(mStall, 16);
        e.fc16 = sat(mFlush, 16);
        e.st4  = sat(mStall, 4);
        e.fc4  = sat(mFlush, 4);
        sb.push_back(e);
        stepNo++;

        // Advance the model across the coming edge.
        if (!rst) begin
            mInit = 1'b1; mPend = 1'b0; mStall = 0; mFlush = 0;
        end else if (mInit) begin
            mInit = 1'b0;
        end else begin
            if (!e.pcw) mStall++;
            if (e.fl) mFlush++;
            if (mPend) mPend = !rdy;
            else       mPend = !lu && br && !rdy;
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) apply(1, 0, 0, 0, 0, 0, rdy);
    endtask

    // Monitor: the DUT presents outputs every cycle; compare mid-cycle against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("PC_write",   e.step, int'(hz16.PC_write),   int'(e.pcw));
                chk("IFID_write", e.step, int'(hz16.IFID_write), int'(e.ifw));
                chk("IF_flush",   e.step, int'(hz16.IF_flush),   int'(e.fl));
                chk("bubble",     e.step, int'(hz16.bubble),     int'(e.bub));
                chk("stall_cnt",  e.step, int'(hz16.stall_cnt),  e.st16);
                chk("flush_cnt",  e.step, int'(hz16.flush_cnt),  e.fc16);
                chk("stall_cnt4", e.step, int'(hz4.stall_cnt),   e.st4);
                chk("flush_cnt4", e.step, int'(hz4.flush_cnt),   e.fc4);
                chk("PC_write4",  e.step, int'(hz4.PC_write),    int'(e.pcw));
            end
        end
    end

    initial begin
        hz16.IDEX_MemRead = 0; hz4.IDEX_MemRead = 0;
        hz16.IDEX_Rt = 0; hz4.IDEX_Rt = 0;
        hz16.IFID_Rs = 0; hz4.IFID_Rs = 0;
        hz16.IFID_Rt = 0; hz4.IFID_Rt = 0;
        hz16.branch_taken = 0; hz4.branch_taken = 0;
        hz16.imem_ready = 1; hz4.imem_ready = 1;

        // Reset for 3 cycles, release: INIT cycle then normal RUN.
        for (int i = 0; i < 3; i++) apply(0, 0, 0, 0, 0, 0, 1);
        idle(3, 1);
        // Load-use on Rs, then the same with r0 as destination.
        apply(1, 1, 5, 5, 0, 0, 1);
        apply(1, 0, 0, 0, 0, 0, 1);
        apply(1, 1, 0, 0, 0, 0, 1);
        apply(1, 1, 7, 2, 7, 0, 1);
        // Load-use together with a taken branch.
        apply(1, 1, 5, 5, 0, 1, 1);
        apply(1, 0, 0, 0, 0, 0, 1);
        // Branch with ready fetch.
        apply(1, 0, 0, 0, 0, 1, 1);
        idle(2, 1);
        // Branch with fetch outstanding: FLUSH_PEND for 3 cycles, then discard.
        apply(0, 0, 0, 0, 0, 0, 1);
        apply(1, 0, 0, 0, 0, 0, 1);
        apply(1, 0, 0, 0, 0, 1, 0);
        apply(1, 1, 5, 5, 5, 1, 0);
        apply(1, 0, 0, 0, 0, 1, 0);
        apply(1, 0, 0, 0, 0, 0, 0);
        apply(1, 1, 3, 3, 0, 1, 1);
        idle(2, 1);
        // Memory stalls long enough to saturate the narrow counters, then reset mid-run.
        idle(20, 0);
        apply(0, 0, 0, 0, 0, 0, 0);
        idle(2, 1);
        // Reset while a discard is pending.
        apply(1, 0, 0, 0, 0, 1, 0);
        apply(1, 0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 1);
        idle(2, 1);

        // Randomized traffic with small register numbers so hazards are frequent.
        for (int i = 0; i < 1500; i++) begin
            apply(($urandom_range(0, 99) >= 2),
                  ($urandom_range(0, 1) == 1),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) != 0));
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            tests++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
